// File: rtl/ram_arbiter_if.sv
// Requester and memory-side signal bundle for ram_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory model.
interface ram_arbiter_if;
    logic        vid_req;
    logic        dl_req;
    logic        cpu_req;
    logic        vid_we;
    logic        dl_we;
    logic        cpu_we;
    logic [20:0] vid_addr;
    logic [20:0] dl_addr;
    logic [20:0] cpu_addr;
    logic [7:0]  vid_wdata;
    logic [7:0]  dl_wdata;
    logic [7:0]  cpu_wdata;
    logic        vid_ack;
    logic        dl_ack;
    logic        cpu_ack;
    logic [7:0]  rdata;
    logic [20:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        mem_oe;
    logic        busy;

    modport slave (
        input  vid_req, dl_req, cpu_req, vid_we, dl_we, cpu_we,
        input  vid_addr, dl_addr, cpu_addr, vid_wdata, dl_wdata, cpu_wdata, mem_din,
        output vid_ack, dl_ack, cpu_ack, rdata, mem_addr, mem_dout, mem_we, mem_oe, busy
    );

    modport master (
        output vid_req, dl_req, cpu_req, vid_we, dl_we, cpu_we,
        output vid_addr, dl_addr, cpu_addr, vid_wdata, dl_wdata, cpu_wdata, mem_din,
        input  vid_ack, dl_ack, cpu_ack, rdata, mem_addr, mem_dout, mem_we, mem_oe, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Three-way (video / download / CPU) arbiter for a single 8-bit async RAM port.
// Optional RAM_ARB_RR_EN: dl and cpu alternate instead of fixed vid > dl > cpu priority.
module ram_arbiter #(
    parameter int unsigned ACC_CYC = 2
) (
    input logic           clk_sys,
    input logic           reset,
    ram_arbiter_if.slave  bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StDone   = 2'd2;

    localparam logic [3:0] CntLoad = 4'(ACC_CYC - 1);

    logic [1:0]  state_q;
    logic [3:0]  cnt_q;
    logic [2:0]  gnt_q;  // {cpu, dl, vid}
    logic [2:0]  ack_q;
    logic [20:0] mem_addr_q;
    logic [7:0]  mem_dout_q;
    logic        mem_we_q;
    logic        mem_oe_q;
    logic [7:0]  rdata_q;

    logic [2:0]  win;
    logic        sel_we;
    logic [20:0] sel_addr;
    logic [7:0]  sel_wdata;

`ifdef RAM_ARB_RR_EN
    logic rr_cpu_first_q;

    always_comb begin
        win = 3'b000;
        if (bus.vid_req) begin
            win = 3'b001;
        end else if (bus.dl_req && bus.cpu_req) begin
            win = rr_cpu_first_q ? 3'b100 : 3'b010;
        end else if (bus.dl_req) begin
            win = 3'b010;
        end else if (bus.cpu_req) begin
            win = 3'b100;
        end
    end

    // Whichever of dl/cpu was served last drops to the back of the pair.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rr_cpu_first_q <= 1'b0;
        end else if (state_q == StIdle) begin
            if (win[1]) begin
                rr_cpu_first_q <= 1'b1;
            end else if (win[2]) begin
                rr_cpu_first_q <= 1'b0;
            end
        end
    end
`else
    always_comb begin
        win = 3'b000;
        if (bus.vid_req) begin
            win = 3'b001;
        end else if (bus.dl_req) begin
            win = 3'b010;
        end else if (bus.cpu_req) begin
            win = 3'b100;
        end
    end
`endif

    always_comb begin
        sel_we    = bus.vid_we;
        sel_addr  = bus.vid_addr;
        sel_wdata = bus.vid_wdata;
        if (win[1]) begin
            sel_we    = bus.dl_we;
            sel_addr  = bus.dl_addr;
            sel_wdata = bus.dl_wdata;
        end else if (win[2]) begin
            sel_we    = bus.cpu_we;
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            gnt_q      <= 3'b000;
            ack_q      <= 3'b000;
            mem_addr_q <= 21'd0;
            mem_dout_q <= 8'd0;
            mem_we_q   <= 1'b0;
            mem_oe_q   <= 1'b0;
            rdata_q    <= 8'd0;
        end else begin
            ack_q <= 3'b000;
            case (state_q)
                StIdle: begin
                    if (|win) begin
                        gnt_q      <= win;
                        mem_addr_q <= sel_addr;
                        mem_dout_q <= sel_wdata;
                        mem_we_q   <= sel_we;
                        mem_oe_q   <= ~sel_we;
                        cnt_q      <= CntLoad;
                        state_q    <= StAccess;
                    end
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        if (mem_oe_q) begin
                            rdata_q <= bus.mem_din;
                        end
                        mem_we_q <= 1'b0;
                        mem_oe_q <= 1'b0;
                        ack_q    <= gnt_q;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.vid_ack  = ack_q[0];
    assign bus.dl_ack   = ack_q[1];
    assign bus.cpu_ack  = ack_q[2];
    assign bus.rdata    = rdata_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_oe   = mem_oe_q;
    assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: u0 runs ACC_CYC=2, u1 runs ACC_CYC=1.
// Cycle 1 is the IDLE cycle in which a request is first sampled.
module tb_ram_arbiter;

    logic clk_sys;
    logic reset;
    int   n_cmp;
    int   n_err;

    ram_arbiter_if bus0 ();
    ram_arbiter_if bus1 ();

    ram_arbiter #(.ACC_CYC(2)) u0 (.clk_sys(clk_sys), .reset(reset), .bus(bus0));
    ram_arbiter #(.ACC_CYC(1)) u1 (.clk_sys(clk_sys), .reset(reset), .bus(bus1));

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] mem_model(input logic [20:0] a);
        return (a == 21'h12345) ? 8'hA5 : (a[7:0] ^ 8'h3C);
    endfunction

    assign bus0.mem_din = mem_model(bus0.mem_addr);
    assign bus1.mem_din = mem_model(bus1.mem_addr);

    task automatic set_req0(input int r, input logic v);
        case (r)
            0:       bus0.vid_req = v;
            1:       bus0.dl_req  = v;
            default: bus0.cpu_req = v;
        endcase
    endtask

    // Issues one transaction on u0 and records what the arbiter did over 13 cycles.
    task automatic txn0(input int r, input logic we, input logic [20:0] addr,
                        input logic [7:0] wd, output int ack_cyc, output int n_ack,
                        output int n_other, output int n_we, output int n_oe,
                        output logic [7:0] rd, output logic bus_ok);
        logic [2:0] a;
        case (r)
            0: begin bus0.vid_we = we; bus0.vid_addr = addr; bus0.vid_wdata = wd; end
            1: begin bus0.dl_we  = we; bus0.dl_addr  = addr; bus0.dl_wdata  = wd; end
            default: begin bus0.cpu_we = we; bus0.cpu_addr = addr; bus0.cpu_wdata = wd; end
        endcase
        set_req0(r, 1'b1);
        ack_cyc = 0; n_ack = 0; n_other = 0; n_we = 0; n_oe = 0; rd = 8'h00; bus_ok = 1'b1;
        for (int k = 2; k <= 14; k++) begin
            @(negedge clk_sys);
            if (bus0.mem_we) n_we++;
            if (bus0.mem_oe) n_oe++;
            if ((bus0.mem_we || bus0.mem_oe) &&
                (bus0.mem_addr !== addr || (we && bus0.mem_dout !== wd))) bus_ok = 1'b0;
            a = {bus0.cpu_ack, bus0.dl_ack, bus0.vid_ack};
            if (a[r]) begin
                n_ack++;
                if (ack_cyc == 0) begin
                    ack_cyc = k;
                    rd = bus0.rdata;
                end
                set_req0(r, 1'b0);
            end
            if ((a & ~(3'b001 << r)) != 3'b000) n_other++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        n_cmp++;
        if ({bus0.vid_ack, bus0.dl_ack, bus0.cpu_ack, bus0.mem_we, bus0.mem_oe, bus0.busy}
            !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl0: got %b want 000000", {bus0.vid_ack, bus0.dl_ack,
                     bus0.cpu_ack, bus0.mem_we, bus0.mem_oe, bus0.busy});
        end
        n_cmp++;
        if ({bus0.mem_addr, bus0.mem_dout, bus0.rdata} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_data0: addr=%h dout=%h rdata=%h want 0", bus0.mem_addr,
                     bus0.mem_dout, bus0.rdata);
        end
        n_cmp++;
        if ({bus1.mem_we, bus1.mem_oe, bus1.busy, bus1.mem_addr, bus1.rdata} !== 32'd0) begin
            n_err++;
            $display("FAIL reset_u1: we=%b oe=%b busy=%b want 0", bus1.mem_we, bus1.mem_oe,
                     bus1.busy);
        end
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_cpu_read;
        int ac, na, no, nw, noe;
        logic [7:0] rd;
        logic ok;
        txn0(2, 1'b0, 21'h12345, 8'h00, ac, na, no, nw, noe, rd, ok);
        n_cmp++;
        if (ac !== 4) begin n_err++; $display("FAIL cpu_read_ack_cycle: got %0d want 4", ac); end
        n_cmp++;
        if (noe !== 2 || nw !== 0) begin
            n_err++; $display("FAIL cpu_read_strobe: oe=%0d we=%0d want 2/0", noe, nw);
        end
        n_cmp++;
        if (rd !== 8'hA5) begin n_err++; $display("FAIL cpu_read_rdata: got %h want a5", rd); end
        n_cmp++;
        if (na !== 1 || no !== 0 || ok !== 1'b1) begin
            n_err++; $display("FAIL cpu_read_acks: acks=%0d other=%0d busok=%b want 1/0/1",
                              na, no, ok);
        end
    endtask

    task automatic test_dl_write;
        int ac, na, no, nw, noe;
        logic [7:0] rd;
        logic ok;
        txn0(1, 1'b1, 21'h1FFFFF, 8'h5A, ac, na, no, nw, noe, rd, ok);
        n_cmp++;
        if (nw !== 2 || noe !== 0) begin
            n_err++; $display("FAIL dl_write_strobe: we=%0d oe=%0d want 2/0", nw, noe);
        end
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL dl_write_bus: addr/dout got wrong"); end
        n_cmp++;
        if (na !== 1 || no !== 0 || ac !== 4) begin
            n_err++; $display("FAIL dl_write_ack: acks=%0d other=%0d cyc=%0d want 1/0/4",
                              na, no, ac);
        end
        n_cmp++;
        if (bus0.rdata !== 8'hA5) begin
            n_err++; $display("FAIL dl_write_rdata_held: got %h want a5", bus0.rdata);
        end
        n_cmp++;
        if (bus0.mem_addr !== 21'h1FFFFF || bus0.mem_dout !== 8'h5A) begin
            n_err++; $display("FAIL idle_retain: addr=%h dout=%h want 1fffff/5a",
                              bus0.mem_addr, bus0.mem_dout);
        end
    endtask

    task automatic test_simultaneous;
        int cyc[3];
        logic [7:0] rd[3];
        int order[$];
        int dbl;
        logic [2:0] a;
        bus0.vid_we = 1'b0; bus0.vid_addr = 21'h00010;
        bus0.dl_we  = 1'b0; bus0.dl_addr  = 21'h00020;
        bus0.cpu_we = 1'b0; bus0.cpu_addr = 21'h00030;
        bus0.vid_req = 1'b1; bus0.dl_req = 1'b1; bus0.cpu_req = 1'b1;
        cyc = '{0, 0, 0}; rd = '{8'h0, 8'h0, 8'h0}; dbl = 0;
        for (int k = 2; k <= 22; k++) begin
            @(negedge clk_sys);
            a = {bus0.cpu_ack, bus0.dl_ack, bus0.vid_ack};
            if ($countones(a) > 1) dbl++;
            for (int r = 0; r < 3; r++) begin
                if (a[r]) begin
                    order.push_back(r);
                    cyc[r] = k;
                    rd[r] = bus0.rdata;
                    set_req0(r, 1'b0);
                end
            end
        end
        n_cmp++;
        if (order.size() !== 3 || order[0] !== 0 || order[1] !== 1 || order[2] !== 2) begin
            n_err++; $display("FAIL simul_order: n=%0d want vid,dl,cpu", order.size());
        end
        n_cmp++;
        if (cyc[0] !== 4 || cyc[1] !== 8 || cyc[2] !== 12) begin
            n_err++; $display("FAIL simul_cycles: got %0d %0d %0d want 4 8 12",
                              cyc[0], cyc[1], cyc[2]);
        end
        n_cmp++;
        if (rd[0] !== 8'h2C || rd[1] !== 8'h1C || rd[2] !== 8'h0C) begin
            n_err++; $display("FAIL simul_rdata: got %h %h %h want 2c 1c 0c",
                              rd[0], rd[1], rd[2]);
        end
        n_cmp++;
        if (dbl !== 0) begin n_err++; $display("FAIL simul_double_ack: got %0d want 0", dbl); end
    endtask

    task automatic test_reset_abort;
        int ac, na, no, nw, noe, stray;
        logic [7:0] rd;
        logic ok;
        bus0.vid_we = 1'b1; bus0.vid_addr = 21'h00100; bus0.vid_wdata = 8'h77;
        bus0.vid_req = 1'b1;
        repeat (2) @(negedge clk_sys);
        n_cmp++;
        if (bus0.mem_we !== 1'b1) begin
            n_err++; $display("FAIL abort_pre_we: got %b want 1", bus0.mem_we);
        end
        reset = 1'b1;
        bus0.vid_req = 1'b0;
        #1;
        n_cmp++;
        if (bus0.mem_we !== 1'b0 || bus0.busy !== 1'b0) begin
            n_err++; $display("FAIL abort_we_drop: we=%b busy=%b want 0/0", bus0.mem_we,
                              bus0.busy);
        end
        @(negedge clk_sys);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_sys);
            if (bus0.vid_ack || bus0.dl_ack || bus0.cpu_ack) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin n_err++; $display("FAIL abort_no_ack: got %0d want 0", stray); end
        txn0(2, 1'b0, 21'h00040, 8'h00, ac, na, no, nw, noe, rd, ok);
        n_cmp++;
        if (ac !== 4 || na !== 1 || rd !== 8'h7C) begin
            n_err++; $display("FAIL abort_recover: cyc=%0d acks=%0d rdata=%h want 4/1/7c",
                              ac, na, rd);
        end
    endtask

    task automatic test_round_robin;
        logic [11:0] seq, exp_seq;
        int n, dbl;
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        bus0.dl_we  = 1'b0; bus0.dl_addr  = 21'h00060;
        bus0.cpu_we = 1'b0; bus0.cpu_addr = 21'h00070;
        bus0.dl_req = 1'b1; bus0.cpu_req = 1'b1;
        seq = 12'd0; n = 0; dbl = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            @(negedge clk_sys);
            if (bus0.dl_ack && bus0.cpu_ack) dbl++;
            if (bus0.dl_ack || bus0.cpu_ack) begin
                seq = {seq[9:0], bus0.cpu_ack, bus0.dl_ack};
                n++;
            end
        end
        bus0.dl_req = 1'b0; bus0.cpu_req = 1'b0;
        repeat (6) @(negedge clk_sys);
`ifdef RAM_ARB_RR_EN
        exp_seq = 12'b01_10_01_10_01_10;
`else
        exp_seq = 12'b01_01_01_01_01_01;
`endif
        n_cmp++;
        if (n !== 6) begin n_err++; $display("FAIL rr_count: got %0d want 6", n); end
        n_cmp++;
        if (seq !== exp_seq) begin
            n_err++; $display("FAIL rr_sequence: got %b want %b", seq, exp_seq);
        end
        n_cmp++;
        if (dbl !== 0) begin n_err++; $display("FAIL rr_double_ack: got %0d want 0", dbl); end
    endtask

    task automatic test_back_to_back;
        int acks[$];
        int idle_gap, n_oe;
        bus1.cpu_we = 1'b0; bus1.cpu_addr = 21'h00050;
        bus1.cpu_req = 1'b1;
        idle_gap = 0; n_oe = 0;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk_sys);
            if (bus1.mem_oe) n_oe++;
            if (acks.size() == 1 && !bus1.busy) idle_gap++;
            if (bus1.cpu_ack) begin
                acks.push_back(k);
                n_cmp++;
                if (bus1.rdata !== 8'h6C) begin
                    n_err++; $display("FAIL b2b_rdata: got %h want 6c", bus1.rdata);
                end
                if (acks.size() == 2) bus1.cpu_req = 1'b0;
            end
        end
        n_cmp++;
        if (acks.size() !== 2 || acks[0] !== 3 || acks[1] !== 6) begin
            n_err++; $display("FAIL b2b_latency: n=%0d want acks at cycles 3 and 6",
                              acks.size());
        end
        n_cmp++;
        if (idle_gap !== 1) begin n_err++; $display("FAIL b2b_idle_gap: got %0d want 1", idle_gap); end
        n_cmp++;
        if (n_oe !== 2) begin n_err++; $display("FAIL b2b_oe: got %0d want 2", n_oe); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus0.vid_req = 1'b0; bus0.dl_req = 1'b0; bus0.cpu_req = 1'b0;
        bus0.vid_we = 1'b0; bus0.dl_we = 1'b0; bus0.cpu_we = 1'b0;
        bus0.vid_addr = '0; bus0.dl_addr = '0; bus0.cpu_addr = '0;
        bus0.vid_wdata = '0; bus0.dl_wdata = '0; bus0.cpu_wdata = '0;
        bus1.vid_req = 1'b0; bus1.dl_req = 1'b0; bus1.cpu_req = 1'b0;
        bus1.vid_we = 1'b0; bus1.dl_we = 1'b0; bus1.cpu_we = 1'b0;
        bus1.vid_addr = '0; bus1.dl_addr = '0; bus1.cpu_addr = '0;
        bus1.vid_wdata = '0; bus1.dl_wdata = '0; bus1.cpu_wdata = '0;
        test_reset();
        test_cpu_read();
        test_dl_write();
        test_simultaneous();
        test_reset_abort();
        test_round_robin();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYC, default 2, memory access strobe length in clk_sys cycles (legal range 1..15).
REQ-002 SHALL have port clk_sys  input  1  system clock (28.636 MHz); all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports vid_req/dl_req/cpu_req  input  1 each  request level (video fetch, ioctl download, CPU).
REQ-005 SHALL have ports vid_we/dl_we/cpu_we  input  1 each  1=write, 0=read.
REQ-006 SHALL have ports vid_addr/dl_addr/cpu_addr  input  21 each  byte address (2 MB).
REQ-007 SHALL have ports vid_wdata/dl_wdata/cpu_wdata  input  8 each  write data.
REQ-008 SHALL have ports vid_ack/dl_ack/cpu_ack  output  1 each  one-cycle completion pulse.
REQ-009 SHALL have port rdata  output  8  read data shared by all requesters; valid in the ack cycle, held until the next read completes.
REQ-010 SHALL have ports mem_addr (output, 21), mem_dout (output, 8), mem_din (input, 8), mem_we (output, 1) and mem_oe (output, 1); all memory outputs registered.
REQ-011 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-012 SHALL implement the states IDLE, ACCESS and DONE.
REQ-013 In IDLE with any request high, SHALL select a winner, register its addr, we and wdata onto the mem_* outputs, load the strobe counter with ACC_CYC-1 and enter ACCESS.
REQ-014 In ACCESS, SHALL hold mem_we (write) or mem_oe (read) high and decrement the counter each cycle.
REQ-015 When the counter is 0 in ACCESS, SHALL capture mem_din into rdata (reads only) and enter DONE in the next cycle; mem_we and mem_oe SHALL go low on entering DONE.
REQ-016 In DONE, SHALL pulse exactly one ack for the granted requester for one cycle, then return to IDLE.
REQ-017 Request-to-ack latency SHALL be ACC_CYC+2 cycles, counted from the first cycle req is sampled high in IDLE.
REQ-018 Requesters SHALL hold req, addr, we and wdata stable until ack; a req still high in the IDLE cycle following ack SHALL be treated as a new transaction.
REQ-019 A requester dropping req before its ack SHALL NOT abort the transaction; that requester's ack SHALL still pulse.
REQ-020 Requests SHALL be sampled only in IDLE; requests arriving during ACCESS or DONE SHALL wait.
REQ-021 Default priority SHALL be vid > dl > cpu (fixed).
REQ-022 On simultaneous requests, SHALL grant exactly one requester; no two acks SHALL ever be high in the same cycle.
REQ-023 mem_addr and mem_dout SHALL retain the last granted values while IDLE.
REQ-024 The strobe counter SHALL be 4 bits and SHALL NOT wrap below 0.

Reset
REQ-025 While reset is high, SHALL force state=IDLE, all acks=0, mem_we=0, mem_oe=0, mem_addr=0, mem_dout=0, rdata=0, busy=0, with no clock edge required.
REQ-026 Reset asserted mid-ACCESS SHALL abort the transaction with no ack and mem_we dropping immediately; the first grant after release SHALL use fresh priority state.

Configuration
REQ-027 Macro RAM_ARB_RR_EN SHALL control round-robin arbitration.
REQ-028 With RAM_ARB_RR_EN defined, vid SHALL remain highest priority, while dl and cpu SHALL alternate when both are pending (last granted of the two gets lower priority; reset state favours dl).
REQ-029 Without RAM_ARB_RR_EN, SHALL use the fixed priority of REQ-021 and SHALL NOT contain a round-robin pointer register.

Verification
REQ-030 Bench SHALL cover: ACC_CYC=2, cpu read of 0x12345 with memory model returning 0xA5 -> mem_oe high for 2 cycles, cpu_ack in cycle 4, rdata=0xA5.
REQ-031 Bench SHALL cover: dl write of 0x5A to 0x1FFFFF -> mem_we high for exactly 2 cycles with mem_addr=0x1FFFFF and mem_dout=0x5A; dl_ack once; rdata unchanged.
REQ-032 Bench SHALL cover: vid, dl and cpu requesting in the same cycle, each held until ack -> acks in order vid, dl, cpu, with 4-cycle spacing plus 1 IDLE cycle between them.
REQ-033 Bench SHALL cover: RAM_ARB_RR_EN defined, dl and cpu requesting continuously for 6 transactions -> grants dl, cpu, dl, cpu, dl, cpu; without the macro -> dl every time, cpu starved.
REQ-034 Bench SHALL cover: reset asserted during the 2nd ACCESS cycle of a write -> mem_we=0 the same cycle, no ack; a cpu request after release completes normally.
REQ-035 Bench SHALL cover: ACC_CYC=1 with back-to-back cpu reads -> 3-cycle latency each, busy low for exactly 1 cycle between them.
